// File: rtl/bus_responder_if.sv
// CPU-side bus bundle for bus_responder: address/direction/write data from
// the CPU, read data and serial status back from the responder.
// With BUS_RESPONDER_IRQ_EN defined, an irq line is added to the bundle.
interface bus_responder_if;
  logic        READ_write;
  logic [15:0] address_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        tx_out;
  logic        tx_busy;
`ifdef BUS_RESPONDER_IRQ_EN
  logic        irq;

  modport master (
    output READ_write, address_in, data_in,
    input  data_out, tx_out, tx_busy, irq
  );

  modport slave (
    input  READ_write, address_in, data_in,
    output data_out, tx_out, tx_busy, irq
  );
`else
  modport master (
    output READ_write, address_in, data_in,
    input  data_out, tx_out, tx_busy
  );

  modport slave (
    input  READ_write, address_in, data_in,
    output data_out, tx_out, tx_busy
  );
`endif
endinterface

// File: rtl/bus_responder.sv
// bus_responder: responder side of the cpu6502 bus.
// Holds on-chip RAM, a 16-byte I/O window (TXDATA, STATUS, DIVL, DIVH, CTRL)
// and a byte-wide serial transmitter fed from a small TX FIFO.
// Reads return data one clock after the address with no wait states.
// Optional feature macro: BUS_RESPONDER_IRQ_EN (adds irq output and CTRL.irq_en).
module bus_responder #(
  parameter int          RAM_ADDR_WIDTH  = 12,
  parameter logic [15:0] IO_BASE         = 16'h8000,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd15
) (
  input  logic            clk_in,
  input  logic            reset,
  bus_responder_if.slave  bus
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int RAM_SIZE = 2 ** RAM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Bus decode
  logic        rd_en;
  logic        wr_en;
  logic        ram_sel;
  logic        io_sel;
  logic [3:0]  io_off;
  logic [7:0]  rd_mux;
  logic [7:0]  rd_data_p1;

  // RAM storage (not reset)
  logic [7:0]  ram [RAM_SIZE];

  // Control / status registers
  logic [15:0] divisor;
  logic        tx_enable;
  logic [7:0]  last_tx;
  logic        overflow;
`ifdef BUS_RESPONDER_IRQ_EN
  logic        irq_en;
  logic        irq_r;
`endif

  // TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;

  // Transmitter
  tx_state_t   state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shifter;
  logic        tx_line;
  logic        frame_done;

  assign wr_en   = bus.READ_write;
  assign rd_en   = ~bus.READ_write;
  assign ram_sel = int'(bus.address_in) < RAM_SIZE;
  assign io_sel  = (bus.address_in[15:4] == IO_BASE[15:4]);
  assign io_off  = bus.address_in[3:0];

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // A push into a full FIFO is dropped and flagged as overflow instead.
  assign push_req = wr_en && io_sel && (io_off == 4'd0);
  assign push     = push_req && !full;

  // The transmitter takes a byte either from idle or at the last clock of a
  // stop bit, which is what makes back-to-back frames gap-free.
  assign frame_done = (state == ST_STOP) && (bit_cnt == '0);
  assign pop        = tx_enable && !empty && ((state == ST_IDLE) || frame_done);

  assign bus.data_out = rd_data_p1;
  assign bus.tx_out   = tx_line;
  assign bus.tx_busy  = (state != ST_IDLE);
`ifdef BUS_RESPONDER_IRQ_EN
  assign bus.irq      = irq_r;
`endif

  // Read data selection from the address map, using pre-edge register values.
  always_comb begin
    rd_mux = 8'hFF;
    if (ram_sel) begin
      rd_mux = ram[bus.address_in[RAM_ADDR_WIDTH-1:0]];
    end else if (io_sel) begin
      case (io_off)
        4'd0:    rd_mux = last_tx;
        4'd1:    rd_mux = {4'b0000, overflow, bus.tx_busy, empty, full};
        4'd2:    rd_mux = divisor[7:0];
        4'd3:    rd_mux = divisor[15:8];
`ifdef BUS_RESPONDER_IRQ_EN
        4'd4:    rd_mux = {6'b000000, irq_en, tx_enable};
`else
        4'd4:    rd_mux = {7'b0000000, tx_enable};
`endif
        default: rd_mux = 8'h00;
      endcase
    end
  end

  // Registered read data; held unchanged across write cycles.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rd_data_p1 <= 8'h00;
    end else if (rd_en) begin
      rd_data_p1 <= rd_mux;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (wr_en && ram_sel) begin
      ram[bus.address_in[RAM_ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  // I/O register writes, sticky overflow and its clear-on-STATUS-read.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      divisor   <= DEFAULT_DIVISOR;
      tx_enable <= 1'b0;
      last_tx   <= 8'h00;
      overflow  <= 1'b0;
`ifdef BUS_RESPONDER_IRQ_EN
      irq_en    <= 1'b0;
`endif
    end else if (wr_en && io_sel) begin
      case (io_off)
        4'd0: begin
          last_tx <= bus.data_in;
          if (full) begin
            overflow <= 1'b1;
          end
        end
        4'd2: divisor[7:0]  <= bus.data_in;
        4'd3: divisor[15:8] <= bus.data_in;
        4'd4: begin
          tx_enable <= bus.data_in[0];
`ifdef BUS_RESPONDER_IRQ_EN
          irq_en    <= bus.data_in[1];
`endif
        end
        default: ;
      endcase
    end else if (rd_en && io_sel && (io_off == 4'd1)) begin
      overflow <= 1'b0;
    end
  end

  // FIFO byte storage; only the pointers and count need reset.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.data_in;
    end
  end

  // FIFO pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serial framing FSM; every bit is reloaded from the live divisor so a
  // divisor change lands on the next bit boundary.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
      tx_line <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_line <= 1'b1;
          if (pop) begin
            shifter <= fifo_mem[rd_ptr];
            bit_cnt <= divisor;
            tx_line <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_cnt == '0) begin
            tx_line <= shifter[0];
            bit_idx <= '0;
            bit_cnt <= divisor;
            state   <= ST_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= divisor;
            if (bit_idx == 3'd7) begin
              tx_line <= 1'b1;
              state   <= ST_STOP;
            end else begin
              tx_line <= shifter[1];
              shifter <= {1'b0, shifter[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_cnt == '0) begin
            if (pop) begin
              shifter <= fifo_mem[rd_ptr];
              bit_cnt <= divisor;
              tx_line <= 1'b0;
              state   <= ST_START;
            end else begin
              state   <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          tx_line <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BUS_RESPONDER_IRQ_EN
  // Interrupt request: FIFO has drained or a byte was lost.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en && (empty || overflow);
    end
  end
`endif

endmodule
